stim_sample_scheduler: RTL and testbench
========================================

# stim_sample_scheduler

Synthesizable test-stimulus controller for the echo-cancellation datapath. It emits a programmed burst of N pseudo-random 16-bit samples at a fixed sample rate derived from the system clock. Each sample is delivered over a valid/ready handshake to the downstream filter input. The block sequences the burst (start, count, done, abort), owns the LFSR sample source and seed, and flags samples the consumer failed to take in time.

## Interface
- CLK_DIV, 250: clocks per sample period; must be ≥2.
- COUNT_W, 16: width of the sample-count and index fields.
- SEED, 16'hACE1: LFSR reset value; also substituted whenever a zero seed is loaded.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a burst; honoured only in IDLE.
- n_samples  in  COUNT_W  burst length; latched on an accepted start.
- abort  in  1  terminates a burst; takes priority over every other input.
- seed_load  in  1  loads `seed` into the LFSR; honoured only in IDLE.
- seed  in  16  new LFSR seed.
- sample_out  out  16  current sample; stable while sample_valid=1.
- sample_valid  out  1  sample_out holds a sample.
- sample_ready  in  1  consumer accepts the sample.
- sample_idx  out  COUNT_W  0-based index of the presented sample.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes normally.
- overrun  out  1  sticky; a sample tick found the previous sample untaken.

## Operation
- States: IDLE, RUN, FIN.
- **IDLE:**
  - start=1 with abort=0 latches n_samples, clears overrun, sample_idx and the divider, and enters RUN.
  - If n_samples=0, it enters FIN instead.
- **Divider:** in RUN, counts 0..CLK_DIV-1 and wraps; "tick" is the cycle where the count equals CLK_DIV-1.
- **Tick handling in RUN:**
  - Slot empty (valid=0), or being accepted at the same edge: step the LFSR once, load sample_out with the new state, set valid=1. If the accept also occurred, sample_idx increments.
  - Slot occupied and not accepted: set overrun=1. The held sample is unchanged and the LFSR does not step, so the tick is skipped.
- **Transfer:** occurs at an edge with valid=1 and sample_ready=1.
  - After a non-final transfer with no coincident tick: valid falls and sample_idx increments.
  - The final transfer (sample_idx = latched N-1): valid falls and the FSM enters FIN.
- **FIN:** done=1 and busy=0 for one cycle, then IDLE.
- **LFSR:** 16-bit Galois, right shift, mask 16'hB400: next = (s>>1) ^ (s[0] ? 16'hB400 : 0).
  - Reloaded only by reset or seed_load. start does not reseed, so successive bursts continue the sequence.
  - seed_load with seed=0 loads SEED.
- **abort:**
  - In RUN: go to IDLE at the next edge with valid=0 and busy=0; done is not pulsed. overrun and sample_idx hold their values.
  - In IDLE: a coincident start is ignored.
- start or seed_load while busy: ignored.

## Timing
- **Reset (async):**
  - state=IDLE, LFSR=SEED, divider=0.
  - sample_out=0, sample_valid=0, sample_idx=0, busy=0, done=0, overrun=0.
- **busy:** rises at the edge accepting start and falls at the final-transfer edge or the abort edge.
- **First sample:** sample_valid rises CLK_DIV edges after the start edge. Later ticks follow every CLK_DIV cycles.
- **done:** high for the single cycle after the final-transfer edge. For N=0, high for the cycle after the start edge.
- All outputs are registered; sample_ready is never combinationally routed to outputs.
- **Minimum sample-to-sample spacing:** CLK_DIV cycles.
- Throughput is lossless when ready is asserted within CLK_DIV-1 cycles of valid.

## Test plan
- **Nominal burst:** CLK_DIV=4, default seed, start with n_samples=3, ready=1.
  - valid rises 4, 8 and 12 cycles after start.
  - sample_out = 16'hE270, 16'h7138, 16'h389C; sample_idx = 0, 1, 2.
  - done pulses once after the third transfer; overrun=0.
- **Zero-length burst:** start with n_samples=0.
  - done=1 exactly one cycle later; valid never rises; busy drops after one cycle.
- **Backpressure:** CLK_DIV=4, n=2, ready held low for 6 cycles after the first valid.
  - overrun=1; sample_out stays 16'hE270 throughout.
  - After ready rises, the next sample is 16'h7138.
- **Seed handling:**
  - seed_load with seed=16'h0001, then n=1: sample 16'hB400.
  - seed_load with seed=0, then n=1: sample 16'hE270.
- **Abort:** abort during RUN while valid=1.
  - Next cycle: valid=0, busy=0, and done stays 0.
  - A following start with n=1 yields the next LFSR value in sequence.
- **Ignored commands and mid-burst reset:** start and seed_load pulsed while busy have no effect on the burst. Asserting rst_n=0 mid-burst immediately forces all outputs to their reset values, and the LFSR returns to 16'hACE1.

Source files
------------

// File: rtl/stim_sample_scheduler.sv
// -----------------------------------------------------------------------------
// stim_sample_scheduler
//
// Test-stimulus controller for the echo-cancellation datapath. On request it
// emits a burst of n_samples pseudo-random 16-bit samples, one per CLK_DIV
// clocks, over a valid/ready handshake. The samples come from a 16-bit Galois
// LFSR. Bursts can be aborted. A sticky flag records any sample tick that
// found the previous sample still untaken.
//
// Ports:
//   clk, rst_n     system clock (rising edge), asynchronous active-low reset
//   start          one-cycle burst request, honoured only when idle
//   n_samples      burst length, latched when start is accepted
//   abort          ends a burst at once; overrides every other input
//   seed_load      loads seed into the LFSR, honoured only when idle
//   seed           new LFSR seed (zero selects SEED)
//   sample_out     current sample, stable while sample_valid is high
//   sample_valid   sample_out holds an untaken sample
//   sample_ready   consumer takes the sample at this edge
//   sample_idx     0-based index of the presented sample
//   busy           burst in progress
//   done           one-cycle pulse after a burst completes normally
//   overrun        sticky: a tick found the previous sample untaken
// -----------------------------------------------------------------------------
module stim_sample_scheduler #(
    parameter int          CLK_DIV = 250,
    parameter int          COUNT_W = 16,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] n_samples,
    input  logic               abort,
    input  logic               seed_load,
    input  logic [15:0]        seed,
    output logic [15:0]        sample_out,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [COUNT_W-1:0] sample_idx,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    localparam int          DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [15:0] POLY  = 16'hB400;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state, state_next;
    logic               busy_next, done_next;
    logic [DIV_W-1:0]   div;
    logic [15:0]        lfsr, lfsr_next;
    logic [COUNT_W-1:0] n_lat;
    logic               tick, xfer, final_xfer, start_ok;

    // A burst is only accepted from IDLE, and abort vetoes a coincident start.
    assign start_ok   = start && !abort;
    assign tick       = (div == DIV_W'(CLK_DIV - 1));
    assign xfer       = sample_valid && sample_ready;
    assign final_xfer = xfer && (sample_idx == n_lat - COUNT_W'(1));
    assign lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? POLY : 16'h0000);

    // ---------------------------------------------------------------- state register
    // busy and done are computed from the next state so they leave a flop
    // rather than a decoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of process ordering.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        // NOTE: default first so no path through the case leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE: if (start_ok) state_next = (n_samples == '0) ? FIN : RUN;
            RUN: begin
                if (abort)           state_next = IDLE;
                else if (final_xfer) state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        busy_next = (state_next == RUN);
        done_next = (state_next == FIN);
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr         <= SEED;
            div          <= '0;
            n_lat        <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            sample_idx   <= '0;
            overrun      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A zero seed would lock the LFSR at zero, so use SEED.
                    if (seed_load) lfsr <= (seed == 16'h0000) ? SEED : seed;
                    if (start_ok) begin
                        n_lat      <= n_samples;
                        overrun    <= 1'b0;
                        sample_idx <= '0;
                        div        <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        sample_valid <= 1'b0;
                    end else begin
                        div <= tick ? '0 : div + DIV_W'(1);
                        if (final_xfer) begin
                            // The last sample never triggers a new one, so the
                            // LFSR is left ready for the next burst.
                            sample_valid <= 1'b0;
                        end else if (tick && (!sample_valid || xfer)) begin
                            lfsr         <= lfsr_next;
                            sample_out   <= lfsr_next;
                            sample_valid <= 1'b1;
                            if (xfer) sample_idx <= sample_idx + COUNT_W'(1);
                        end else if (tick) begin
                            // Slot still occupied: skip this tick, keep the sample.
                            overrun <= 1'b1;
                        end else if (xfer) begin
                            sample_valid <= 1'b0;
                            sample_idx   <= sample_idx + COUNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stim_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_stim_sample_scheduler
//
// Directed bench for stim_sample_scheduler with CLK_DIV=4. The stimulus thread
// pushes hand-computed {sample, index} pairs into a scoreboard queue before
// each burst; an independent monitor pops and compares on every handshake.
// Timing, control flags and reset behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_stim_sample_scheduler;

    localparam int CLK_DIV = 4;
    localparam int COUNT_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [COUNT_W-1:0] n_samples = '0;
    logic               abort = 1'b0;
    logic               seed_load = 1'b0;
    logic [15:0]        seed = '0;
    logic [15:0]        sample_out;
    logic               sample_valid;
    logic               sample_ready = 1'b0;
    logic [COUNT_W-1:0] sample_idx;
    logic               busy;
    logic               done;
    logic               overrun;

    stim_sample_scheduler #(
        .CLK_DIV (CLK_DIV),
        .COUNT_W (COUNT_W),
        .SEED    (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .n_samples    (n_samples),
        .abort        (abort),
        .seed_load    (seed_load),
        .seed         (seed),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_idx   (sample_idx),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0]        smp;
        logic [COUNT_W-1:0] idx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake seen at the negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && sample_valid && sample_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=0x%0h idx=%0d expected=none", sample_out, sample_idx);
            end else begin
                mon_e = sb.pop_front();
                check("sb_sample", {16'h0, sample_out}, {16'h0, mon_e.smp});
                check("sb_idx", {16'h0, sample_idx}, {16'h0, mon_e.idx});
            end
        end
    end

    task automatic push(input logic [15:0] s, input int i);
        exp_t e;
        e.smp = s;
        e.idx = COUNT_W'(i);
        sb.push_back(e);
    endtask

    task automatic start_burst(input int n);
        @(posedge clk); #1;
        start     = 1'b1;
        n_samples = COUNT_W'(n);
        @(posedge clk);
        start_cyc = cyc;
        #1 start = 1'b0;
    endtask

    task automatic load_seed(input logic [15:0] s);
        @(posedge clk); #1;
        seed_load = 1'b1;
        seed      = s;
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1;
        sample_ready = r;
    endtask

    // Waits for sample_valid and checks how many edges after the start edge it rose.
    task automatic wait_valid(input string name, input int exp_dly);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sample_valid && k < 64);
        check({name, "_valid"}, {31'h0, sample_valid}, 32'h1);
        check({name, "_dly"}, cyc - start_cyc - 1, exp_dly);
    endtask

    // Waits for done, checks it lasts exactly one cycle with busy low.
    task automatic wait_done(input string name, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 64);
        check({name, "_done"}, {31'h0, done}, 32'h1);
        check({name, "_busy_fin"}, {31'h0, busy}, 32'h0);
        @(negedge clk);
        check({name, "_done_fall"}, {31'h0, done}, 32'h0);
        check({name, "_busy_after"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int cnt;

        // ---------------- reset state
        #12;
        check("rst_sample", {16'h0, sample_out}, 32'h0);
        check("rst_valid", {31'h0, sample_valid}, 32'h0);
        check("rst_idx", {16'h0, sample_idx}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        rst_n = 1'b1;

        // ---------------- nominal burst, default seed
        set_ready(1'b1);
        push(16'hE270, 0);
        push(16'h7138, 1);
        push(16'h389C, 2);
        start_burst(3);
        wait_valid("nom_s0", 4);
        check("nom_busy", {31'h0, busy}, 32'h1);
        wait_valid("nom_s1", 8);
        wait_valid("nom_s2", 12);
        wait_done("nom", d);
        check("nom_overrun", {31'h0, overrun}, 32'h0);

        // ---------------- zero-length burst
        start_burst(0);
        wait_done("zero", d);
        check("zero_latency", d, 1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sample_valid) cnt++;
        end
        check("zero_no_valid", cnt, 0);

        // ---------------- backpressure (reseed to default first)
        load_seed(16'h0000);
        set_ready(1'b0);
        push(16'hE270, 0);
        push(16'h7138, 1);
        start_burst(2);
        wait_valid("bp_s0", 4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_hold", {16'h0, sample_out}, 32'hE270);
        end
        check("bp_overrun", {31'h0, overrun}, 32'h1);
        set_ready(1'b1);
        wait_done("bp", d);
        check("bp_overrun_sticky", {31'h0, overrun}, 32'h1);

        // ---------------- seed handling
        load_seed(16'h0001);
        push(16'hB400, 0);
        start_burst(1);
        wait_valid("seed1", 4);
        wait_done("seed1", d);
        load_seed(16'h0000);
        push(16'hE270, 0);
        start_burst(1);
        wait_valid("seed0", 4);
        wait_done("seed0", d);

        // ---------------- abort in IDLE vetoes a coincident start
        @(posedge clk); #1;
        start     = 1'b1;
        abort     = 1'b1;
        n_samples = COUNT_W'(1);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", {31'h0, busy}, 32'h0);
        check("idle_abort_done", {31'h0, done}, 32'h0);

        // ---------------- abort during RUN with a sample held
        set_ready(1'b0);
        start_burst(3);
        wait_valid("abort_s0", 4);
        check("abort_sample", {16'h0, sample_out}, 32'h7138);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_valid", {31'h0, sample_valid}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_idx_hold", {16'h0, sample_idx}, 32'h0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) cnt++;
            @(negedge clk);
        end
        check("abort_no_done", cnt, 0);
        set_ready(1'b1);
        push(16'h389C, 0);
        start_burst(1);
        wait_valid("post_abort", 4);
        wait_done("post_abort", d);

        // ---------------- start and seed_load while busy are ignored
        push(16'h1C4E, 0);
        push(16'h0E27, 1);
        push(16'hB313, 2);
        start_burst(3);
        wait_valid("ign_s0", 4);
        @(posedge clk); #1;
        start     = 1'b1;
        n_samples = COUNT_W'(1);
        seed_load = 1'b1;
        seed      = 16'h0001;
        @(posedge clk); #1;
        start     = 1'b0;
        seed_load = 1'b0;
        wait_done("ign", d);

        // ---------------- asynchronous reset mid-burst
        set_ready(1'b0);
        start_burst(3);
        wait_valid("mrst_s0", 4);
        check("mrst_sample", {16'h0, sample_out}, 32'hED89);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("mrst_sample_out", {16'h0, sample_out}, 32'h0);
        check("mrst_valid", {31'h0, sample_valid}, 32'h0);
        check("mrst_idx", {16'h0, sample_idx}, 32'h0);
        check("mrst_busy", {31'h0, busy}, 32'h0);
        check("mrst_done", {31'h0, done}, 32'h0);
        check("mrst_overrun", {31'h0, overrun}, 32'h0);
        #2 rst_n = 1'b1;
        set_ready(1'b1);
        push(16'hE270, 0);
        start_burst(1);
        wait_valid("mrst_after", 4);
        wait_done("mrst_after", d);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
